pool_ctrl: RTL and testbench
============================

# pool_ctrl

Sequential controller for 2×2/stride-2 pooling of one N×N signed 16-bit feature map. It fetches pixels from a single-port image buffer one word per cycle, assembles each 2×2 window in registers, and reduces it through the existing `pool_window` max unit. It writes one pooled word per window to the output buffer. It sits between the conv-layer output RAM and the next layer's input RAM, started by the layer sequencer.

## Interface
- `N`, 28: image side; must be even and ≥2; elaboration error otherwise
- `DW`, 16: pixel width (signed)
- `AW`, `$clog2(N*N)`: image address width (derived; do not override)
- `OW`, `$clog2(N*N/4)`: pooled address width (derived; do not override)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request; honoured only in IDLE
- `busy` out 1: high while a map is being processed
- `done` out 1: one-cycle pulse after the final write
- `rd_en` out 1: image buffer read strobe
- `rd_addr` out AW: image word address, row-major
- `rd_data` in DW: read data; valid exactly 1 cycle after `rd_en`
- `wr_en` out 1: pooled buffer write strobe
- `wr_addr` out OW: pooled word address, row-major
- `wr_data` out DW: pooled value

## Operation
- FSM states: IDLE → RD (4 cycles, k=0..3) → CAP → WR → RD (next window) or FIN → IDLE.
- Window (r,c), with r and c even, is read in this order:
  - r*N+c
  - r*N+c+1
  - (r+1)*N+c
  - (r+1)*N+c+1
- Windows are visited row-major: c advances by 2, then r advances by 2.
- Output address = (r/2)*(N/2) + c/2, so the output order is also row-major.
- RD k: `rd_en`=1 with address k. `rd_data` from the previous cycle is captured into window register k-1 (k≥1).
- CAP: `rd_en`=0; `rd_data` is captured into window register 3.
- WR: `wr_en`=1, `wr_data` = signed max of the 4 registers, `wr_addr` = current output index.
  - If the last window was just written, go to FIN; otherwise go to RD.
- FIN: `done`=1, `busy`=0 on the following cycle, return to IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- All comparisons are signed two's complement. Ties are irrelevant, since equal values are identical.
- Reset mid-operation aborts immediately. The partial output is left in RAM and no `done` is issued.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0. FSM in IDLE, counters 0.
- `start` high in IDLE at cycle t:
  - `busy`=1 and the first `rd_en` at t+1.
- Each window takes 6 cycles: 4 RD, 1 CAP, 1 WR.
- First write at t+6. Window w is written at t+6+6w.
- `done` pulses at t+6·(N²/4)+1; `busy` is low at the same cycle.
  - N=28: `done` at t+1177.
- `start` is accepted in the cycle after FIN (IDLE), so back-to-back maps are spaced by 1 idle cycle.
- `rd_en` and `wr_en` are never high in the same cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `POOL_AVG_EN`, when defined: average pooling.
  - WR outputs floor((a+b+c+d)/4).
  - Computed as an 18-bit signed sum followed by an arithmetic shift right by 2, then truncated to DW. The result always fits.
  - `pool_window` is not instantiated.
- Undefined (default): max pooling via `pool_window`.
- Latency and handshakes are identical in both builds.

## Structure
- Shared package `cnn_pkg`:
  - `PIX_W`=16
  - `typedef logic signed [PIX_W-1:0] pix_t`
  - `typedef pix_t win_t [0:3]`
  - the `pool_state_t` enum (IDLE, RD, CAP, WR, FIN)
- Sub-module: reuse the existing `pool_window` on the 4-entry `win_t` register array. No new sub-module is required; the average path is inline under the macro.
- Counters: k (2 bits), c and r (each $clog2(N) bits), output index (OW bits).

## Test plan
- N=4, image = 0..15 row-major, max build → writes 5,7,13,15 at addresses 0,1,2,3. `done` at t+25.
- N=4, image = -(0..15) → writes 0,-2,-8,-10. Confirms signed compare.
- N=4, `POOL_AVG_EN`, image 0..15 → writes 2,4,10,12. Window {-1,-2,-2,-2} → -2 (floor, not truncate toward zero).
- `start` pulsed again at t+3 and t+10 while busy → ignored. Exactly 4 writes and one `done`.
- `rst_n` deasserted at t+8 (mid-window 1) → all outputs 0 asynchronously. After release, no `wr_en` or `done` until the next `start`. A new run is correct.
- N=28, random data → 196 writes matching the golden model. `rd_addr` sequence is exact. `done` at t+1177. No cycle has `rd_en`&&`wr_en`.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath package.
// Provides the pixel type, the 4-entry pooling window type and the pooling
// controller state encoding used by pool_ctrl and pool_window.
package cnn_pkg;

    localparam int PIX_W = 16;

    typedef logic signed [PIX_W-1:0] pix_t;
    typedef pix_t win_t [0:3];

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        FIN  = 3'd4
    } pool_state_t;

endpackage

// File: rtl/pool_window.sv
// Signed maximum of a 2x2 pooling window (purely combinational).
// Ports:
//   win     - four signed pixels of the window
//   max_val - largest of the four (two's complement compare)
module pool_window
    import cnn_pkg::*;
(
    input  win_t win,
    output pix_t max_val
);

    pix_t max_top;
    pix_t max_bot;

    always_comb begin
        max_top = (win[0] > win[1]) ? win[0] : win[1];
        max_bot = (win[2] > win[3]) ? win[2] : win[3];
        max_val = (max_top > max_bot) ? max_top : max_bot;
    end

endmodule

// File: rtl/pool_ctrl.sv
// 2x2 / stride-2 pooling controller for one N x N signed feature map.
// Reads four pixels per window from a single-port image buffer (1-cycle read
// latency), reduces them, and writes one pooled word per window, row-major.
//
// Build option: define POOL_AVG_EN for average pooling (floor of sum/4);
// otherwise max pooling through pool_window. Timing is identical.
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   start             - one-cycle request, honoured only when idle
//   busy, done        - map in progress / one-cycle completion pulse
//   rd_en, rd_addr    - image buffer read strobe and row-major word address
//   rd_data           - image data, valid one cycle after rd_en
//   wr_en, wr_addr    - pooled buffer write strobe and row-major address
//   wr_data           - pooled value
module pool_ctrl
    import cnn_pkg::*;
#(
    parameter int N  = 28,
    parameter int DW = 16,
    parameter int AW = $clog2(N*N),
    parameter int OW = ((N*N/4) > 1) ? $clog2(N*N/4) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          wr_en,
    output logic [OW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    localparam int CW = $clog2(N);

    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_RD   = RD;
    localparam logic [2:0] ST_CAP  = CAP;
    localparam logic [2:0] ST_WR   = WR;
    localparam logic [2:0] ST_FIN  = FIN;

    localparam logic [CW-1:0] LAST = CW'(N - 2);
    localparam logic [AW-1:0] N_A  = AW'(N);

    if ((N < 2) || ((N % 2) != 0)) begin : g_bad_n
        $error("pool_ctrl: N must be even and >= 2");
    end
    if (DW != PIX_W) begin : g_bad_dw
        $error("pool_ctrl: DW must equal PIX_W");
    end

    logic [2:0]    state_reg,   state_next;
    logic [1:0]    k_reg,       k_next;
    logic [CW-1:0] r_reg,       r_next;
    logic [CW-1:0] c_reg,       c_next;
    logic [OW-1:0] o_reg,       o_next;
    logic          busy_reg,    busy_next;
    logic          done_reg,    done_next;
    logic          rd_en_reg,   rd_en_next;
    logic [AW-1:0] rd_addr_reg, rd_addr_next;
    logic          wr_en_reg,   wr_en_next;
    logic [OW-1:0] wr_addr_reg, wr_addr_next;
    logic [DW-1:0] wr_data_reg, wr_data_next;

    // Window slots 0..2 are held in registers. The fourth pixel arrives on
    // rd_data during CAP and feeds the reducer directly, so the result can be
    // registered straight into wr_data for the WR cycle.
    win_t cap_win;
    pix_t pooled;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_win
        pix_t q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if ((state_reg == ST_RD) && (k_reg == 2'(gi + 1))) begin
                q <= rd_data;
            end
        end
        assign cap_win[gi] = q;
    end
    assign cap_win[3] = rd_data;

`ifdef POOL_AVG_EN
    // 18-bit sum cannot overflow; arithmetic shift gives floor division.
    logic signed [DW+1:0] sum4;
    assign sum4 = {{2{cap_win[0][DW-1]}}, cap_win[0]} +
                  {{2{cap_win[1][DW-1]}}, cap_win[1]} +
                  {{2{cap_win[2][DW-1]}}, cap_win[2]} +
                  {{2{cap_win[3][DW-1]}}, cap_win[3]};
    assign pooled = pix_t'(sum4 >>> 2);
`else
    pool_window u_pool_window (
        .win     (cap_win),
        .max_val (pooled)
    );
`endif

    always_comb begin
        state_next   = state_reg;
        k_next       = k_reg;
        r_next       = r_reg;
        c_next       = c_reg;
        o_next       = o_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RD;
                    k_next     = '0;
                    r_next     = '0;
                    c_next     = '0;
                    o_next     = '0;
                    busy_next  = 1'b1;
                end
            end
            ST_RD: begin
                if (k_reg == 2'd3) begin
                    state_next = ST_CAP;
                end else begin
                    k_next = k_reg + 2'd1;
                end
            end
            ST_CAP: begin
                state_next   = ST_WR;
                wr_en_next   = 1'b1;
                wr_addr_next = o_reg;
                wr_data_next = pooled;
            end
            ST_WR: begin
                if ((r_reg == LAST) && (c_reg == LAST)) begin
                    state_next = ST_FIN;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    state_next = ST_RD;
                    k_next     = '0;
                    o_next     = o_reg + OW'(1);
                    if (c_reg == LAST) begin
                        c_next = '0;
                        r_next = r_reg + CW'(2);
                    end else begin
                        c_next = c_reg + CW'(2);
                    end
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase

        // Read strobe/address are registered from the next-cycle counters so
        // they line up with the RD state they belong to.
        rd_en_next   = (state_next == ST_RD);
        rd_addr_next = rd_en_next ?
                       (AW'(r_next) * N_A + AW'(c_next) +
                        (k_next[1] ? N_A : '0) + AW'(k_next[0])) :
                       rd_addr_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            k_reg       <= '0;
            r_reg       <= '0;
            c_reg       <= '0;
            o_reg       <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            rd_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            r_reg       <= r_next;
            c_reg       <= c_next;
            o_reg       <= o_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            rd_en_reg   <= rd_en_next;
            rd_addr_reg <= rd_addr_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rd_en   = rd_en_reg;
    assign rd_addr = rd_addr_reg;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl: an N=4 instance for hand-computed vectors and
// an N=28 instance for a full-size map against a golden model.
module tb_pool_ctrl;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- N = 4 instance ----------------
    logic               start4, busy4, done4, rd_en4, wr_en4;
    logic [3:0]         rd_addr4;
    logic [1:0]         wr_addr4;
    logic signed [15:0] rd_data4 = '0;
    logic signed [15:0] wr_data4;
    logic signed [15:0] mem4 [0:15];

    pool_ctrl #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4)
    );

    // ---------------- N = 28 instance ----------------
    logic               start28, busy28, done28, rd_en28, wr_en28;
    logic [9:0]         rd_addr28;
    logic [7:0]         wr_addr28;
    logic signed [15:0] rd_data28 = '0;
    logic signed [15:0] wr_data28;
    logic signed [15:0] mem28 [0:783];

    pool_ctrl #(.N(28)) dut28 (
        .clk(clk), .rst_n(rst_n), .start(start28), .busy(busy28), .done(done28),
        .rd_en(rd_en28), .rd_addr(rd_addr28), .rd_data(rd_data28),
        .wr_en(wr_en28), .wr_addr(wr_addr28), .wr_data(wr_data28)
    );

    // Image buffers: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en4)  rd_data4  <= mem4[rd_addr4];
        if (rd_en28) rd_data28 <= mem28[rd_addr28];
    end

    // Monitors sample on the falling edge.
    wr_t wq4[$];
    wr_t wq28[$];
    int  done_q4[$];
    int  done_q28[$];
    int  busy_at_done4;
    int  busy_at_done28;
    int  rd_q28[$];
    int  ovl4  = 0;
    int  ovl28 = 0;

    always @(negedge clk) begin
        if (wr_en4) begin
            wq4.push_back('{cyc, int'(wr_addr4), int'(wr_data4)});
            $display("[cyc %0d] N4  write addr=%0d data=%0d", cyc, wr_addr4, wr_data4);
        end
        if (done4) begin
            done_q4.push_back(cyc);
            busy_at_done4 = int'(busy4);
        end
        if (rd_en4 && wr_en4) ovl4++;
        if (wr_en28) begin
            wq28.push_back('{cyc, int'(wr_addr28), int'(wr_data28)});
            $display("[cyc %0d] N28 write addr=%0d data=%0d", cyc, wr_addr28, wr_data28);
        end
        if (done28) begin
            done_q28.push_back(cyc);
            busy_at_done28 = int'(busy28);
        end
        if (rd_en28) rd_q28.push_back(int'(rd_addr28));
        if (rd_en28 && wr_en28) ovl28++;
    end

    int exp_ramp[4];
    int exp_neg[4];
    int exp_tie[4];

    // ---------------- helpers (stimulus only) ----------------
    task automatic clear4();
        wq4.delete();
        done_q4.delete();
        ovl4 = 0;
    endtask

    task automatic load4(input int sel);
        for (int i = 0; i < 16; i++) begin
            case (sel)
                0:       mem4[i] = 16'(i);
                1:       mem4[i] = 16'(-i);
                default: mem4[i] = 16'(0);
            endcase
        end
        if (sel == 2) begin
            mem4[0] = -16'sd1;
            mem4[1] = -16'sd2;
            mem4[4] = -16'sd2;
            mem4[5] = -16'sd2;
        end
    endtask

    task automatic start4_pulse(output int t0);
        @(negedge clk);
        start4 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait_done4(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_q4.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic int gold28(input int r, input int c);
        int a[4];
        int s;
        a[0] = int'(mem28[r*28 + c]);
        a[1] = int'(mem28[r*28 + c + 1]);
        a[2] = int'(mem28[(r+1)*28 + c]);
        a[3] = int'(mem28[(r+1)*28 + c + 1]);
`ifdef POOL_AVG_EN
        s = a[0] + a[1] + a[2] + a[3];
        return ((s < 0) && (s % 4 != 0)) ? (s / 4 - 1) : (s / 4);
`else
        s = a[0];
        for (int i = 1; i < 4; i++) if (a[i] > s) s = a[i];
        return s;
`endif
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start4 = 1'b0;
        start28 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy4 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy4); else n_pass++;
        n_checks++; if (done4 !== 1'b0) $display("FAIL reset_done: got %b want 0", done4); else n_pass++;
        n_checks++; if (rd_en4 !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rd_en4); else n_pass++;
        n_checks++; if (rd_addr4 !== 4'd0) $display("FAIL reset_rd_addr: got %0d want 0", rd_addr4); else n_pass++;
        n_checks++; if (wr_en4 !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en4); else n_pass++;
        n_checks++; if (wr_addr4 !== 2'd0) $display("FAIL reset_wr_addr: got %0d want 0", wr_addr4); else n_pass++;
        n_checks++; if (wr_data4 !== 16'sd0) $display("FAIL reset_wr_data: got %0d want 0", wr_data4); else n_pass++;
        n_checks++;
        if ({busy28, done28, rd_en28, wr_en28} !== 4'b0 || rd_addr28 !== 10'd0 || wr_data28 !== 16'sd0)
            $display("FAIL reset_n28: busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%0d wr_data=%0d want all 0",
                     busy28, done28, rd_en28, wr_en28, rd_addr28, wr_data28);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pattern(input string name, input int sel, input int exp[4]);
        int t0;
        bit ok;
        load4(sel);
        clear4();
        start4_pulse(t0);
        n_checks++; if (busy4 !== 1'b1 || rd_en4 !== 1'b1 || rd_addr4 !== 4'd0)
            $display("FAIL %s_first_cycle: busy=%b rd_en=%b rd_addr=%0d want 1 1 0", name, busy4, rd_en4, rd_addr4);
        else n_pass++;
        wait_done4(60, ok);
        repeat (2) @(negedge clk);
        n_checks++; if (!ok) $display("FAIL %s_timeout: no done within 60 cycles", name); else n_pass++;
        n_checks++; if (wq4.size() != 4) $display("FAIL %s_write_count: got %0d want 4", name, wq4.size()); else n_pass++;
        for (int w = 0; w < 4; w++) begin
            if (wq4.size() > w) begin
                n_checks++;
                if (wq4[w].addr != w || wq4[w].data != exp[w] || wq4[w].cyc != t0 + 6 + 6*w)
                    $display("FAIL %s_write%0d: addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                             name, w, wq4[w].addr, wq4[w].data, wq4[w].cyc, w, exp[w], t0 + 6 + 6*w);
                else n_pass++;
            end
        end
        n_checks++;
        if (done_q4.size() != 1 || done_q4[0] != t0 + 25 || busy_at_done4 != 0)
            $display("FAIL %s_done: pulses=%0d cyc=%0d busy=%0d want 1 pulse at %0d busy 0",
                     name, done_q4.size(), (done_q4.size() > 0) ? done_q4[0] : -1, busy_at_done4, t0 + 25);
        else n_pass++;
        n_checks++; if (ovl4 != 0) $display("FAIL %s_rd_wr_overlap: got %0d cycles want 0", name, ovl4); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int t0;
        bit ok;
        load4(0);
        clear4();
        start4_pulse(t0);
        while (cyc < t0 + 3) @(negedge clk);
        start4 = 1'b1; @(negedge clk); start4 = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        start4 = 1'b1; @(negedge clk); start4 = 1'b0;
        wait_done4(60, ok);
        repeat (40) @(negedge clk);
        n_checks++; if (wq4.size() != 4) $display("FAIL ignore_write_count: got %0d want 4", wq4.size()); else n_pass++;
        n_checks++;
        if (done_q4.size() != 1 || done_q4[0] != t0 + 25)
            $display("FAIL ignore_done: pulses=%0d cyc=%0d want 1 pulse at %0d",
                     done_q4.size(), (done_q4.size() > 0) ? done_q4[0] : -1, t0 + 25);
        else n_pass++;
        n_checks++;
        if (wq4.size() == 4 && (wq4[3].data != exp_ramp[3] || wq4[3].addr != 3))
            $display("FAIL ignore_last_write: addr=%0d data=%0d want 3 %0d", wq4[3].addr, wq4[3].data, exp_ramp[3]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t0;
        int d;
        bit ok;
        load4(0);
        clear4();
        start4_pulse(t0);
        wait_done4(60, ok);
        d = (done_q4.size() > 0) ? done_q4[0] : t0 + 25;
        while (cyc < d + 1) @(negedge clk);
        start4 = 1'b1; @(negedge clk); start4 = 1'b0;
        n_checks++; if (busy4 !== 1'b1 || rd_en4 !== 1'b1)
            $display("FAIL b2b_restart: busy=%b rd_en=%b at cyc %0d want 1 1", busy4, rd_en4, cyc);
        else n_pass++;
        repeat (30) @(negedge clk);
        n_checks++;
        if (done_q4.size() != 2 || done_q4[1] != d + 26)
            $display("FAIL b2b_done: pulses=%0d second=%0d want 2 pulses, second at %0d",
                     done_q4.size(), (done_q4.size() > 1) ? done_q4[1] : -1, d + 26);
        else n_pass++;
        n_checks++;
        if (wq4.size() != 8 || wq4[4].data != exp_ramp[0] || wq4[4].addr != 0 || wq4[4].cyc != d + 7)
            $display("FAIL b2b_writes: count=%0d want 8 with write4 addr 0 data %0d at %0d",
                     wq4.size(), exp_ramp[0], d + 7);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t0;
        load4(0);
        clear4();
        start4_pulse(t0);
        while (cyc < t0 + 8) @(negedge clk);
        n_checks++; if (busy4 !== 1'b1 || wr_data4 !== 16'(exp_ramp[0]))
            $display("FAIL midrst_before: busy=%b wr_data=%0d want 1 %0d", busy4, wr_data4, exp_ramp[0]);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy4, done4, rd_en4, wr_en4} !== 4'b0 || rd_addr4 !== 4'd0 || wr_addr4 !== 2'd0 || wr_data4 !== 16'sd0)
            $display("FAIL midrst_async: busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d wr_data=%0d want all 0",
                     busy4, done4, rd_en4, wr_en4, rd_addr4, wr_addr4, wr_data4);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear4();
        repeat (30) @(negedge clk);
        n_checks++; if (wq4.size() != 0 || done_q4.size() != 0 || busy4 !== 1'b0)
            $display("FAIL midrst_quiet: writes=%0d dones=%0d busy=%b want 0 0 0", wq4.size(), done_q4.size(), busy4);
        else n_pass++;
    endtask

    task automatic test_n28_random();
        int t0;
        bit ok;
        int idx;
        int bad_rd;
        for (int i = 0; i < 784; i++) mem28[i] = 16'($urandom);
        wq28.delete(); done_q28.delete(); rd_q28.delete(); ovl28 = 0;
        @(negedge clk);
        start28 = 1'b1; t0 = cyc;
        @(negedge clk);
        start28 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1300; i++) begin
            if (done_q28.size() > 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        n_checks++; if (!ok) $display("FAIL n28_timeout: no done within 1300 cycles"); else n_pass++;
        n_checks++; if (wq28.size() != 196) $display("FAIL n28_write_count: got %0d want 196", wq28.size()); else n_pass++;
        for (int r = 0; r < 28; r += 2) begin
            for (int c = 0; c < 28; c += 2) begin
                idx = (r / 2) * 14 + c / 2;
                if (wq28.size() > idx) begin
                    n_checks++;
                    if (wq28[idx].addr != idx || wq28[idx].data != gold28(r, c) || wq28[idx].cyc != t0 + 6 + 6*idx)
                        $display("FAIL n28_write%0d: addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                                 idx, wq28[idx].addr, wq28[idx].data, wq28[idx].cyc, idx, gold28(r, c), t0 + 6 + 6*idx);
                    else n_pass++;
                end
            end
        end
        bad_rd = -1;
        idx = 0;
        for (int r = 0; r < 28; r += 2)
            for (int c = 0; c < 28; c += 2)
                for (int k = 0; k < 4; k++) begin
                    if (bad_rd < 0 && (idx >= rd_q28.size() || rd_q28[idx] != (r + k/2)*28 + c + k%2))
                        bad_rd = idx;
                    idx++;
                end
        n_checks++;
        if (bad_rd >= 0 || rd_q28.size() != 784)
            $display("FAIL n28_rd_addr_seq: reads=%0d first bad index=%0d want 784 exact", rd_q28.size(), bad_rd);
        else n_pass++;
        n_checks++;
        if (done_q28.size() != 1 || done_q28[0] != t0 + 1177 || busy_at_done28 != 0)
            $display("FAIL n28_done: pulses=%0d cyc=%0d busy=%0d want 1 pulse at %0d busy 0",
                     done_q28.size(), (done_q28.size() > 0) ? done_q28[0] : -1, busy_at_done28, t0 + 1177);
        else n_pass++;
        n_checks++; if (ovl28 != 0) $display("FAIL n28_rd_wr_overlap: got %0d cycles want 0", ovl28); else n_pass++;
    endtask

    initial begin
`ifdef POOL_AVG_EN
        exp_ramp = '{2, 4, 10, 12};
        exp_neg  = '{-3, -5, -11, -13};
        exp_tie  = '{-2, 0, 0, 0};
`else
        exp_ramp = '{5, 7, 13, 15};
        exp_neg  = '{0, -2, -8, -10};
        exp_tie  = '{-1, 0, 0, 0};
`endif
        test_reset();
        test_pattern("ramp", 0, exp_ramp);
        test_pattern("neg_ramp", 1, exp_neg);
        test_pattern("neg_window", 2, exp_tie);
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_pattern("after_reset", 0, exp_ramp);
        test_n28_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
